// File: rtl/div_unit_pkg.sv
// Shared encodings and constants for the RV32M sequential divider.
package div_unit_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    FIN  = 2'b11
  } state_e;

  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;
  localparam int          ITER     = 32;

  function automatic logic [31:0] neg2c(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

endpackage

// File: rtl/div_unit_add.sv
// Shared add block: a + b + cin, carry-out reported on of_o.
module div_unit_add #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             of_o
);

  assign {of_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};

endmodule

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU with START/BUSY/DONE handshake.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [1:0]       OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic             DZ
);

  localparam int CW = $clog2(WIDTH);

  state_e           state_q;
  op_e              op_q;
  logic [WIDTH-1:0] r_q, q_q, d_q;
  logic             neg_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q, dz_q;
  logic [WIDTH-1:0] result_q;

  logic             signed_in, rem_in;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] t, diff, sel, fixed;
  logic             carry, take;

  assign signed_in = (OP == OP_DIV) || (OP == OP_REM);
  assign rem_in    = (OP == OP_REM) || (OP == OP_REMU);
  assign a_mag     = (signed_in && A[WIDTH-1]) ? neg2c(A) : A;
  assign b_mag     = (signed_in && B[WIDTH-1]) ? neg2c(B) : B;

  // Trial subtraction T - D as T + ~D + 1; carry-out means no borrow.
  assign t = {r_q[WIDTH-2:0], q_q[WIDTH-1]};

  div_unit_add #(.WIDTH(WIDTH)) trial_sub (
    .a_i   (t),
    .b_i   (~d_q),
    .cin_i (1'b1),
    .sum_o (diff),
    .of_o  (carry)
  );

  // R[31] set means the shifted partial remainder exceeds 32 bits, so it always fits.
  assign take  = r_q[WIDTH-1] | carry;
  assign sel   = ((op_q == OP_REM) || (op_q == OP_REMU)) ? r_q : q_q;
  assign fixed = neg_q ? neg2c(sel) : sel;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      op_q     <= OP_DIV;
      r_q      <= '0;
      q_q      <= '0;
      d_q      <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, FIN: begin
          if (START) begin
            op_q <= op_e'(OP);
            if (B == '0) begin
              result_q <= rem_in ? A : ALL_ONES;
              dz_q     <= 1'b1;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
              state_q  <= FIN;
            end else if (signed_in && A == INT_MIN && B == ALL_ONES) begin
              result_q <= rem_in ? '0 : INT_MIN;
              dz_q     <= 1'b0;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
              state_q  <= FIN;
            end else begin
              r_q     <= '0;
              q_q     <= a_mag;
              d_q     <= b_mag;
              neg_q   <= signed_in & (rem_in ? A[WIDTH-1] : (A[WIDTH-1] ^ B[WIDTH-1]));
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= CALC;
            end
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        CALC: begin
          r_q   <= take ? diff : t;
          q_q   <= {q_q[WIDTH-2:0], take};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(ITER - 1)) state_q <= FIX;
        end
        FIX: begin
          result_q <= fixed;
          dz_q     <= 1'b0;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= FIN;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign RESULT = result_q;
  assign DZ     = dz_q;

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
Sequential radix-2 restoring divider implementing the RV32M DIV, DIVU, REM and REMU operations for the 32-bit RISC-V core. It is the subtractive counterpart of the CLA adder datapath: each cycle produces one quotient bit from a trial subtraction computed by the existing 32-bit add block. It sits beside the ALU as a multi-cycle execution unit with a START/BUSY/DONE handshake. The control stalls on BUSY.

Parameters:
WIDTH, 32, operand/result width. Only 32 is supported; the parameter exists for the iteration counter and constant sizing.

Ports:
CLK  input  1  clock; all state updates on rising edge
RST  input  1  reset, asynchronous, active-high
START  input  1  request; sampled only when BUSY=0
OP  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
A  input  32  dividend; sampled with START
B  input  32  divisor; sampled with START
BUSY  output  1  unit computing; new START ignored
DONE  output  1  one-cycle pulse; RESULT valid
RESULT  output  32  quotient or remainder; held until next load
DZ  output  1  divide-by-zero flag; updated with RESULT, valid when DONE=1

Behaviour:
- Clocking and reset: one clock CLK. RST is asynchronous and active-high. Reset forces state IDLE, BUSY=0, DONE=0, RESULT=0, DZ=0, counter=0, and clears the internal registers.
- Reset mid-operation aborts the operation with no DONE pulse. The first START after RST deasserts is accepted normally.
- States:
  - IDLE: BUSY=0, DONE=0.
  - CALC: BUSY=1, counter 0..31.
  - FIX: BUSY=1.
  - FIN: BUSY=0, DONE=1.
- Accept: START=1 on an edge while in IDLE or FIN (edge k).
  - Latch OP.
  - Signed ops (DIV, REM): latch |A| and |B| and record the quotient sign (A[31]^B[31]) and remainder sign (A[31]).
  - Unsigned ops: latch raw A and B.
- Special cases resolved at edge k, going directly to FIN; DONE is high in the cycle after edge k:
  - B==0: RESULT = 0xFFFFFFFF for DIV/DIVU; RESULT = A for REM/REMU; DZ=1.
  - DIV/REM with A=0x80000000 and B=0xFFFFFFFF: RESULT = 0x80000000 (DIV) or 0 (REM); DZ=0.
- Normal path: edge k goes to CALC, counter=0, R=0, Q=dividend magnitude.
- Each CALC edge:
  - T = {R[30:0], Q[31]}; diff = T + ~D + 1, computed by add with CIN=1; carry = OF.
  - If R[31] | carry: R ← diff, Q ← {Q[30:0], 1}.
  - Otherwise: R ← T, Q ← {Q[30:0], 0}.
  - Counter increments. After the counter=31 edge (edge k+32), go to FIX.
- FIX edge (k+33):
  - Select Q for DIV/DIVU, R for REM/REMU.
  - Negate (two's complement) if the op is signed and the recorded sign is 1.
  - Load RESULT, set DZ=0, go to FIN.
- Latency: DONE is high in the cycle after edge k+33, i.e. 34 cycles after the START edge (1 cycle for special cases).
- FIN lasts exactly one cycle. It goes to IDLE, or restarts if START=1 (back-to-back issue allowed).
- START while BUSY=1 is ignored. Operands and results are unaffected.
- RESULT and DZ hold their value through IDLE until the next load.

Decomposition:
- Shared package:
  - OP encodings: OP_DIV, OP_DIVU, OP_REM, OP_REMU.
  - State encoding: IDLE, CALC, FIX, FIN.
  - Constants: INT_MIN = 0x80000000, ALL_ONES = 0xFFFFFFFF, ITER = 32.
- Sub-module: reuse the existing add block (instance "trial_sub") for the per-cycle trial subtraction. Its OF output is the no-borrow carry. Magnitude/negation logic stays inline; no new sub-module.

Test Plan:
- DIVU A=100 B=7, START at edge 0 -> BUSY=1 for edges 1..33; DONE=1 exactly one cycle after edge 33; RESULT=14, DZ=0. Repeat with REMU -> RESULT=2.
- DIV A=0xFFFFFFF9 (-7) B=2 -> RESULT=0xFFFFFFFD (-3). REM with the same operands -> RESULT=0xFFFFFFFF (-1). DIVU A=0xFFFFFFFF B=1 -> RESULT=0xFFFFFFFF.
- DIVU A=5 B=0 -> DONE in the cycle after the START edge, RESULT=0xFFFFFFFF, DZ=1. REM A=0xFFFFFFF9 B=0 -> RESULT=0xFFFFFFF9, DZ=1.
- DIV A=0x80000000 B=0xFFFFFFFF -> 1-cycle DONE, RESULT=0x80000000. REM with the same operands -> RESULT=0, DZ=0.
- START with A=9 B=3 pulsed at edge 10 while BUSY -> ignored. First op's RESULT is unchanged and exactly one DONE per accepted START. Back-to-back START during FIN -> second result 34 cycles later.
- RST asserted asynchronously at CALC edge 15 -> BUSY, DONE, RESULT and DZ go to 0 immediately with no DONE pulse. Next DIVU 100/7 completes with RESULT=14.
